// File: rtl/ctrl_pipe_if.sv
// Purpose: ID-side control inputs and per-stage control outputs of the control pipeline.
// Latency: none, wires only.
// Backpressure: ifid_hold from the pipe stalls the producer (PC / IF-ID register).
interface ctrl_pipe_if #(
  parameter int CTRL_W = 15
);
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              ex_redirect;
  logic              mem_busy;

  logic              ex_valid;
  logic              mem_valid;
  logic              wb_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [CTRL_W-1:0] wb_ctrl;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_dst;
  logic [4:0]        mem_dst;
  logic [4:0]        wb_dst;
  logic              ifid_hold;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  // Decoder / front-end side
  modport master (
    output id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_redirect, mem_busy,
    input  ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
    input  ex_rs, ex_rt, ex_dst, mem_dst, wb_dst, ifid_hold, fwd_a, fwd_b
  );

  // Control pipeline side
  modport slave (
    input  id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_redirect, mem_busy,
    output ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
    output ex_rs, ex_rt, ex_dst, mem_dst, wb_dst, ifid_hold, fwd_a, fwd_b
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Purpose: carries decoded control ID->EX->MEM->WB, inserts hazard bubbles, squashes on redirect. Macro FWD_EN enables forwarding.
// Latency: 1 cycle per stage (ID->WB 3 cycles); ifid_hold and fwd_a/fwd_b are combinational.
// Backpressure: mem_busy freezes every stage; stall_cond holds IF/ID and bubbles EX.
module ctrl_pipe #(
  parameter int         CTRL_W = 15,
  parameter logic [4:0] REG_RA = 5'd31
) (
  input logic         clk,
  input logic         reset,
  ctrl_pipe_if.slave  bus
);

  // Control bundle bit positions
  localparam int B_SAVEPC   = 14;
  localparam int B_REGWRITE = 9;
  localparam int B_ALUSRC   = 7;
  localparam int B_MEMWRITE = 6;
  localparam int B_MEMREAD  = 4;
  localparam int B_BRANCH   = 2;
  localparam int B_JUMP     = 1;
  localparam int B_REGDST   = 0;

  logic              ex_valid, mem_valid, wb_valid;
  logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]        ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;

  logic [4:0] id_dst;
  logic       uses_rs, uses_rt;
  logic       hz_ex, load_use, stall_cond, advance;

  // Destination of the ID instruction; non-writers carry 0 so they can never match a source
  always_comb begin
    id_dst = 5'd0;
    if (bus.id_ctrl[B_REGWRITE]) begin
      if (bus.id_ctrl[B_SAVEPC])      id_dst = REG_RA;
      else if (bus.id_ctrl[B_REGDST]) id_dst = bus.id_rd;
      else                            id_dst = bus.id_rt;
    end
  end

  // Which source fields the ID instruction really reads ($0 is never a dependency)
  assign uses_rs = !bus.id_ctrl[B_JUMP] && (bus.id_rs != 5'd0);
  assign uses_rt = (!bus.id_ctrl[B_ALUSRC] || bus.id_ctrl[B_MEMWRITE] || bus.id_ctrl[B_BRANCH])
                   && (bus.id_rt != 5'd0);

  assign hz_ex = ex_valid && ex_ctrl[B_REGWRITE] && (ex_dst != 5'd0) &&
                 ((uses_rs && (ex_dst == bus.id_rs)) || (uses_rt && (ex_dst == bus.id_rt)));
  assign load_use = hz_ex && ex_ctrl[B_MEMREAD];

`ifdef FWD_EN
  // Only a load in EX cannot be forwarded in time
  assign stall_cond = load_use;

  // Operand select for EX: MEM result (non-load) beats WB result
  always_comb begin
    bus.fwd_a = 2'b00;
    bus.fwd_b = 2'b00;
    if (mem_valid && mem_ctrl[B_REGWRITE] && !mem_ctrl[B_MEMREAD] && (ex_rs != 5'd0) && (mem_dst == ex_rs))
      bus.fwd_a = 2'b10;
    else if (wb_valid && wb_ctrl[B_REGWRITE] && (ex_rs != 5'd0) && (wb_dst == ex_rs))
      bus.fwd_a = 2'b01;
    if (mem_valid && mem_ctrl[B_REGWRITE] && !mem_ctrl[B_MEMREAD] && (ex_rt != 5'd0) && (mem_dst == ex_rt))
      bus.fwd_b = 2'b10;
    else if (wb_valid && wb_ctrl[B_REGWRITE] && (ex_rt != 5'd0) && (wb_dst == ex_rt))
      bus.fwd_b = 2'b01;
  end
`else
  logic hz_mem;
  assign hz_mem = mem_valid && mem_ctrl[B_REGWRITE] && (mem_dst != 5'd0) &&
                  ((uses_rs && (mem_dst == bus.id_rs)) || (uses_rt && (mem_dst == bus.id_rt)));
  // Without forwarding any RAW against EX or MEM waits until the producer reaches WB
  assign stall_cond = hz_ex || hz_mem;
  assign bus.fwd_a  = 2'b00;
  assign bus.fwd_b  = 2'b00;
`endif

  assign advance       = bus.id_valid && !bus.ex_redirect && !stall_cond;
  // Redirect overrides a stall so fetch can take the new PC
  assign bus.ifid_hold = !reset &&
                         (bus.mem_busy || (bus.id_valid && !bus.ex_redirect && stall_cond));

  // Stage registers: freeze on mem_busy, otherwise shift and load EX or a zeroed bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
      ex_ctrl   <= '0;
      mem_ctrl  <= '0;
      wb_ctrl   <= '0;
      ex_rs     <= 5'd0;
      ex_rt     <= 5'd0;
      ex_dst    <= 5'd0;
      mem_dst   <= 5'd0;
      wb_dst    <= 5'd0;
    end else if (!bus.mem_busy) begin
      wb_valid  <= mem_valid;
      wb_ctrl   <= mem_ctrl;
      wb_dst    <= mem_dst;
      mem_valid <= ex_valid;
      mem_ctrl  <= ex_ctrl;
      mem_dst   <= ex_dst;
      if (advance) begin
        ex_valid <= 1'b1;
        ex_ctrl  <= bus.id_ctrl;
        ex_rs    <= bus.id_rs;
        ex_rt    <= bus.id_rt;
        ex_dst   <= id_dst;
      end else begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_rs    <= 5'd0;
        ex_rt    <= 5'd0;
        ex_dst   <= 5'd0;
      end
    end
  end

  assign bus.ex_valid  = ex_valid;
  assign bus.mem_valid = mem_valid;
  assign bus.wb_valid  = wb_valid;
  assign bus.ex_ctrl   = ex_ctrl;
  assign bus.mem_ctrl  = mem_ctrl;
  assign bus.wb_ctrl   = wb_ctrl;
  assign bus.ex_rs     = ex_rs;
  assign bus.ex_rt     = ex_rt;
  assign bus.ex_dst    = ex_dst;
  assign bus.mem_dst   = mem_dst;
  assign bus.wb_dst    = wb_dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Purpose: directed, table-driven check of ctrl_pipe stage flow, hazards, redirect, freeze and reset.
// Latency: expectations sampled #1 after edges; hold sampled mid-cycle.
// Backpressure: bench holds ID stimulus itself while a stall is expected.
module tb_ctrl_pipe;

  localparam logic [14:0] C_ADDU = 15'h0A01;
  localparam logic [14:0] C_SUBU = 15'h1A01;
  localparam logic [14:0] C_LW   = 15'h03B0;
  localparam logic [14:0] C_JAL  = 15'h4202;
  localparam logic [14:0] C_BEQ  = 15'h0404;

  typedef struct {
    string       name;
    logic        vld;
    logic [14:0] ctrl;
    logic [4:0]  rs, rt, rd;
    logic        hold;
    logic        ex_vld;
    logic [14:0] ex_ctrl;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
    logic [1:0]  fa, fb;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  logic hold_s;
  vec_t vecs[$];

  ctrl_pipe_if bus ();
  ctrl_pipe dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic add_vec(input string nm, input logic v, input logic [14:0] c,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic h, input logic ev, input logic [14:0] ec,
                         input logic [4:0] ed, input logic [4:0] md, input logic [4:0] wd,
                         input logic [1:0] fa, input logic [1:0] fb);
    vec_t t;
    t.name = nm; t.vld = v; t.ctrl = c; t.rs = rs; t.rt = rt; t.rd = rd;
    t.hold = h; t.ex_vld = ev; t.ex_ctrl = ec; t.ex_dst = ed; t.mem_dst = md; t.wb_dst = wd;
    t.fa = fa; t.fb = fb;
    vecs.push_back(t);
  endtask

  // Drive one ID cycle at negedge, sample hold mid-cycle, return #1 after the posedge
  task automatic cyc(input logic v, input logic [14:0] c, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd, input logic redir, input logic busy);
    @(negedge clk);
    bus.id_valid = v; bus.id_ctrl = c; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.ex_redirect = redir; bus.mem_busy = busy;
    #1 hold_s = bus.ifid_hold;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 15'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.id_valid = 1'b0; bus.id_ctrl = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.ex_redirect = 1'b0; bus.mem_busy = 1'b0;
    #2;
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 0);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 0);
    chk("rst_ex_ctrl", {17'd0, bus.ex_ctrl}, 0);
    chk("rst_hold", {31'd0, bus.ifid_hold}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Straight-line flow, JAL link dest, $0 writer and $0 readers
    add_vec("jal",   1, C_JAL,  0, 0, 0, 0, 1, C_JAL,  31, 0,  0,  2'b00, 2'b00);
    add_vec("add0",  1, C_ADDU, 5, 6, 0, 0, 1, C_ADDU, 0,  31, 0,  2'b00, 2'b00);
    add_vec("rd_r0", 1, C_ADDU, 0, 0, 7, 0, 1, C_ADDU, 7,  0,  31, 2'b00, 2'b00);
    add_vec("beq",   1, C_BEQ,  9, 10, 0, 0, 1, C_BEQ, 0,  7,  0,  2'b00, 2'b00);
    add_vec("idle1", 0, 15'h0,  0, 0, 0, 0, 0, 15'h0,  0,  0,  7,  2'b00, 2'b00);
    add_vec("idle2", 0, 15'h0,  0, 0, 0, 0, 0, 15'h0,  0,  0,  0,  2'b00, 2'b00);

    foreach (vecs[i]) begin
      cyc(vecs[i].vld, vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, 1'b0, 1'b0);
      chk({vecs[i].name, "_hold"}, {31'd0, hold_s}, {31'd0, vecs[i].hold});
      chk({vecs[i].name, "_exv"}, {31'd0, bus.ex_valid}, {31'd0, vecs[i].ex_vld});
      chk({vecs[i].name, "_exc"}, {17'd0, bus.ex_ctrl}, {17'd0, vecs[i].ex_ctrl});
      chk({vecs[i].name, "_exd"}, {27'd0, bus.ex_dst}, {27'd0, vecs[i].ex_dst});
      chk({vecs[i].name, "_memd"}, {27'd0, bus.mem_dst}, {27'd0, vecs[i].mem_dst});
      chk({vecs[i].name, "_wbd"}, {27'd0, bus.wb_dst}, {27'd0, vecs[i].wb_dst});
      chk({vecs[i].name, "_fa"}, {30'd0, bus.fwd_a}, {30'd0, vecs[i].fa});
      chk({vecs[i].name, "_fb"}, {30'd0, bus.fwd_b}, {30'd0, vecs[i].fb});
    end

    // Load-use: lw $8 then addu $9,$8,$8
    cyc(1, C_LW, 1, 8, 0, 0, 0);
    chk("lu_lw_exd", {27'd0, bus.ex_dst}, 8);
    cyc(1, C_ADDU, 8, 8, 9, 0, 0);
    chk("lu_hold1", {31'd0, hold_s}, 1);
    chk("lu_bub_v", {31'd0, bus.ex_valid}, 0);
    chk("lu_bub_c", {17'd0, bus.ex_ctrl}, 0);
`ifdef FWD_EN
    cyc(1, C_ADDU, 8, 8, 9, 0, 0);
    chk("lu_hold2", {31'd0, hold_s}, 0);
    chk("lu_exd", {27'd0, bus.ex_dst}, 9);
    chk("lu_fa", {30'd0, bus.fwd_a}, 2'b01);
    chk("lu_fb", {30'd0, bus.fwd_b}, 2'b01);
`else
    cyc(1, C_ADDU, 8, 8, 9, 0, 0);
    chk("lu_hold2", {31'd0, hold_s}, 1);
    chk("lu_bub2_v", {31'd0, bus.ex_valid}, 0);
    chk("lu_wbd", {27'd0, bus.wb_dst}, 8);
    cyc(1, C_ADDU, 8, 8, 9, 0, 0);
    chk("lu_hold3", {31'd0, hold_s}, 0);
    chk("lu_exd", {27'd0, bus.ex_dst}, 9);
    chk("lu_fa", {30'd0, bus.fwd_a}, 0);
`endif
    idle(3);

    // ALU RAW: addu $3 then subu $4,$3,$3
    cyc(1, C_ADDU, 1, 2, 3, 0, 0);
    chk("raw_hold0", {31'd0, hold_s}, 0);
    cyc(1, C_SUBU, 3, 3, 4, 0, 0);
`ifdef FWD_EN
    chk("raw_hold1", {31'd0, hold_s}, 0);
    chk("raw_exd", {27'd0, bus.ex_dst}, 4);
    chk("raw_memd", {27'd0, bus.mem_dst}, 3);
    chk("raw_fa", {30'd0, bus.fwd_a}, 2'b10);
    chk("raw_fb", {30'd0, bus.fwd_b}, 2'b10);
`else
    chk("raw_hold1", {31'd0, hold_s}, 1);
    chk("raw_bub1", {31'd0, bus.ex_valid}, 0);
    cyc(1, C_SUBU, 3, 3, 4, 0, 0);
    chk("raw_hold2", {31'd0, hold_s}, 1);
    chk("raw_bub2", {31'd0, bus.ex_valid}, 0);
    chk("raw_wbd", {27'd0, bus.wb_dst}, 3);
    cyc(1, C_SUBU, 3, 3, 4, 0, 0);
    chk("raw_hold3", {31'd0, hold_s}, 0);
    chk("raw_exd", {27'd0, bus.ex_dst}, 4);
    chk("raw_memv", {31'd0, bus.mem_valid}, 0);
`endif
    idle(3);

    // Redirect while a load-use stall is pending
    cyc(1, C_LW, 1, 8, 0, 0, 0);
    cyc(1, C_ADDU, 8, 8, 9, 1, 0);
    chk("rd_hold", {31'd0, hold_s}, 0);
    chk("rd_exv", {31'd0, bus.ex_valid}, 0);
    chk("rd_memv", {31'd0, bus.mem_valid}, 1);
    chk("rd_memd", {27'd0, bus.mem_dst}, 8);
    idle(3);

    // Freeze on mem_busy for 3 cycles
    cyc(1, C_ADDU, 1, 2, 10, 0, 0);
    cyc(1, C_ADDU, 1, 2, 11, 0, 0);
    cyc(1, C_ADDU, 1, 2, 12, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, C_ADDU, 1, 2, 13, 0, 1);
      chk($sformatf("busy%0d_hold", k), {31'd0, hold_s}, 1);
      chk($sformatf("busy%0d_exd", k), {27'd0, bus.ex_dst}, 12);
      chk($sformatf("busy%0d_memd", k), {27'd0, bus.mem_dst}, 11);
      chk($sformatf("busy%0d_wbd", k), {27'd0, bus.wb_dst}, 10);
      chk($sformatf("busy%0d_wbv", k), {31'd0, bus.wb_valid}, 1);
    end
    cyc(1, C_ADDU, 1, 2, 13, 0, 0);
    chk("resume_hold", {31'd0, hold_s}, 0);
    chk("resume_exd", {27'd0, bus.ex_dst}, 13);
    chk("resume_memd", {27'd0, bus.mem_dst}, 12);
    chk("resume_wbd", {27'd0, bus.wb_dst}, 11);

    // Async reset mid-cycle with three valid instructions in flight
    #2;
    reset = 1'b1;
    bus.mem_busy = 1'b1;
    #1;
    chk("mrst_exv", {31'd0, bus.ex_valid}, 0);
    chk("mrst_memv", {31'd0, bus.mem_valid}, 0);
    chk("mrst_wbv", {31'd0, bus.wb_valid}, 0);
    chk("mrst_memc", {17'd0, bus.mem_ctrl}, 0);
    chk("mrst_wbd", {27'd0, bus.wb_dst}, 0);
    chk("mrst_hold", {31'd0, bus.ifid_hold}, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    chk("post_rst_wbv", {31'd0, bus.wb_valid}, 0);
    chk("post_rst_memd", {27'd0, bus.mem_dst}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
